vector_element_streamer: RTL and testbench

//  Read-side companion to the vector register: captures one I-lane x L-bit vector on Start and

---
 rtl/vector_pkg.sv | 21 ++
 rtl/vector_element_streamer_if.sv | 32 +++
 rtl/vector_element_streamer_counter.sv | 29 ++
 rtl/vector_element_streamer.sv | 102 ++++++++++
 tb/tb_vector_element_streamer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_pkg.sv
// Shared types for the vector element streamer.
// Lane types here use default widths; modules re-derive them from their own parameters.
package vector_pkg;

  localparam int DEF_I = 2;
  localparam int DEF_L = 4;

  typedef logic [DEF_L-1:0] elem_t;
  typedef logic [DEF_I-1:0][DEF_L-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } strm_state_t;

  function automatic int clamp_count(input int cnt, input int lanes);
    return (cnt > lanes) ? lanes : cnt;
  endfunction

endpackage

// File: rtl/vector_element_streamer_if.sv
// Element-serial valid/ready channel.
// Carries lane data, lane index and a last-element flag.
interface vector_element_streamer_if #(
  parameter int I = 2,
  parameter int L = 4
);

  localparam int IW = $clog2(I);

  logic          Elem_Valid;
  logic          Elem_Ready;
  logic [L-1:0]  Elem_Data;
  logic [IW-1:0] Elem_Idx;
  logic          Elem_Last;

  modport master (
    output Elem_Valid,
    output Elem_Data,
    output Elem_Idx,
    output Elem_Last,
    input  Elem_Ready
  );

  modport slave (
    input  Elem_Valid,
    input  Elem_Data,
    input  Elem_Idx,
    input  Elem_Last,
    output Elem_Ready
  );

endinterface

// File: rtl/vector_element_streamer_counter.sv
// Lane index counter for the streamer.
// Loads zero, increments on enable, flags the final lane of the latched count.
module elem_index_counter #(
  parameter  int I  = 2,
  localparam int IW = $clog2(I),
  localparam int CW = $clog2(I + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          inc,
  input  logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          term
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + IW'(1);
    end
  end

  assign term = (CW'(idx) + CW'(1)) == cnt;

endmodule

// File: rtl/vector_element_streamer.sv
// Captures one vector on Start and streams its first Count lanes,
// lane 0 first, one element per valid/ready transfer.
module vector_element_streamer
  import vector_pkg::*;
#(
  parameter  int I  = 2,
  parameter  int L  = 4,
  localparam int IW = $clog2(I),
  localparam int CW = $clog2(I + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [CW-1:0]        Count,
  input  logic [I-1:0][L-1:0]  Data_In,
  output logic                 Busy,
  output logic                 Done,
  vector_element_streamer_if.master elem
);

  strm_state_t state_q;
  strm_state_t state_d;

  logic [I-1:0][L-1:0] shadow;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_in;
  logic [IW-1:0]       idx;
  logic                term;
  logic                load;
  logic                inc;
  logic                valid;
  logic                xfer;

  // Oversized requests are clipped to the lane count.
  assign cnt_in = (Count > CW'(I)) ? CW'(I) : Count;

  assign valid = (state_q == STREAM);
  assign xfer  = valid && elem.Elem_Ready;
  assign inc   = xfer && !term;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      shadow <= Data_In;
      cnt_q  <= cnt_in;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          state_d = (cnt_in == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (xfer && term) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  elem_index_counter #(
    .I (I)
  ) u_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load (load),
    .inc  (inc),
    .cnt  (cnt_q),
    .idx  (idx),
    .term (term)
  );

  assign Busy            = (state_q != IDLE);
  assign Done            = (state_q == DONE);
  assign elem.Elem_Valid = valid;
  assign elem.Elem_Idx   = idx;
  assign elem.Elem_Last  = valid && term;
  assign elem.Elem_Data  = valid ? shadow[idx] : '0;

endmodule

// File: tb/tb_vector_element_streamer.sv
// Randomized and directed bench for vector_element_streamer.
// A queue-based reference model predicts each cycle's outputs.
module tb_vector_element_streamer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RST;
  logic            Start;
  logic [2:0]      Count;
  logic [3:0][7:0] Data_In;
  logic            Busy;
  logic            Done;

  logic            Start2;
  logic [1:0]      Count2;
  logic [1:0][3:0] Data2;
  logic            Busy2;
  logic            Done2;

  vector_element_streamer_if #(.I(4), .L(8)) e4 ();
  vector_element_streamer_if #(.I(2), .L(4)) e2 ();

  vector_element_streamer #(.I(4), .L(8)) u4 (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .Count   (Count),
    .Data_In (Data_In),
    .Busy    (Busy),
    .Done    (Done),
    .elem    (e4)
  );

  vector_element_streamer #(.I(2), .L(4)) u2 (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start2),
    .Count   (Count2),
    .Data_In (Data2),
    .Busy    (Busy2),
    .Done    (Done2),
    .elem    (e2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } ent_t;

  ent_t exq[$];
  bit   done_m;
  int   checks;
  int   errors;
  int   xfers;
  int   dones;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_outputs(input string tag);
    bit v;
    v = (exq.size() > 0);
    chk({tag, " valid"}, 32'(e4.Elem_Valid), 32'(v));
    chk({tag, " busy"}, 32'(Busy), 32'(v || done_m));
    chk({tag, " done"}, 32'(Done), 32'(done_m));
    if (v) begin
      chk({tag, " data"}, 32'(e4.Elem_Data), 32'(exq[0].d));
      chk({tag, " idx"}, 32'(e4.Elem_Idx), 32'(exq[0].i));
      chk({tag, " last"}, 32'(e4.Elem_Last), 32'(exq[0].l));
    end else begin
      chk({tag, " data0"}, 32'(e4.Elem_Data), 32'h0);
      chk({tag, " last0"}, 32'(e4.Elem_Last), 32'h0);
    end
  endtask

  // Advance one clock edge: predict, clock, compare, return at negedge.
  task automatic cyc(input string tag);
    bit nd;
    int n;
    nd = 1'b0;
    if (e4.Elem_Valid && e4.Elem_Ready) xfers++;
    if (done_m) begin
      nd = 1'b0;
    end else if (exq.size() > 0) begin
      if (e4.Elem_Ready) begin
        void'(exq.pop_front());
        if (exq.size() == 0) nd = 1'b1;
      end
    end else if (Start) begin
      n = (int'(Count) > 4) ? 4 : int'(Count);
      for (int k = 0; k < n; k++) begin
        exq.push_back('{d: Data_In[k], i: 2'(k), l: (k == n - 1)});
      end
      if (n == 0) nd = 1'b1;
    end
    @(posedge CLK);
    #1;
    done_m = nd;
    if (Done) dones++;
    cmp_outputs(tag);
    @(negedge CLK);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 32'(Busy), 32'h0);
    chk({tag, " done"}, 32'(Done), 32'h0);
    chk({tag, " valid"}, 32'(e4.Elem_Valid), 32'h0);
    chk({tag, " last"}, 32'(e4.Elem_Last), 32'h0);
    chk({tag, " data"}, 32'(e4.Elem_Data), 32'h0);
    chk({tag, " idx"}, 32'(e4.Elem_Idx), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_m = 1'b0;
    RST = 1'b1;
    Start = 1'b0;
    Count = '0;
    Data_In = '0;
    e4.Elem_Ready = 1'b0;
    Start2 = 1'b0;
    Count2 = '0;
    Data2 = '0;
    e2.Elem_Ready = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 1: full vector, ready held high
    Data_In = {8'h44, 8'h33, 8'h22, 8'h11};
    Count = 3'd4;
    Start = 1'b1;
    e4.Elem_Ready = 1'b1;
    xfers = 0;
    dones = 0;
    cyc("t1");
    Start = 1'b0;
    run("t1", 6);
    chk("t1 xfers", 32'(xfers), 32'd4);
    chk("t1 dones", 32'(dones), 32'd1);

    // 2: count 2 with backpressure
    Count = 3'd2;
    Start = 1'b1;
    xfers = 0;
    dones = 0;
    cyc("t2");
    Start = 1'b0;
    e4.Elem_Ready = 1'b1;
    cyc("t2");
    e4.Elem_Ready = 1'b0;
    cyc("t2");
    cyc("t2");
    e4.Elem_Ready = 1'b1;
    run("t2", 4);
    chk("t2 xfers", 32'(xfers), 32'd2);
    chk("t2 dones", 32'(dones), 32'd1);

    // 3: zero count
    Count = 3'd0;
    Start = 1'b1;
    xfers = 0;
    dones = 0;
    cyc("t3");
    chk("t3 done", 32'(Done), 32'h1);
    Start = 1'b0;
    run("t3", 3);
    chk("t3 xfers", 32'(xfers), 32'd0);
    chk("t3 dones", 32'(dones), 32'd1);

    // 4: clamp, restart attempts mid-stream ignored
    Data_In = {8'h44, 8'h33, 8'h22, 8'h11};
    Count = 3'd7;
    Start = 1'b1;
    xfers = 0;
    dones = 0;
    cyc("t4");
    Data_In = {4{8'hFF}};
    run("t4", 4);
    Start = 1'b0;
    run("t4", 3);
    chk("t4 xfers", 32'(xfers), 32'd4);
    chk("t4 dones", 32'(dones), 32'd1);

    // 5: async reset during element 2
    Data_In = {8'h44, 8'h33, 8'h22, 8'h11};
    Count = 3'd4;
    Start = 1'b1;
    dones = 0;
    cyc("t5");
    Start = 1'b0;
    cyc("t5");
    chk("t5 idx1", 32'(e4.Elem_Idx), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk_zero("t5 rst");
    exq.delete();
    done_m = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    run("t5 idle", 2);
    chk("t5 nodone", 32'(dones), 32'd0);
    Count = 3'd1;
    Start = 1'b1;
    xfers = 0;
    cyc("t5b");
    Start = 1'b0;
    chk("t5b data", 32'(e4.Elem_Data), 32'h11);
    chk("t5b last", 32'(e4.Elem_Last), 32'h1);
    run("t5b", 3);
    chk("t5b xfers", 32'(xfers), 32'd1);
    chk("t5b dones", 32'(dones), 32'd1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      Start = ($urandom_range(0, 3) == 0);
      Count = 3'($urandom_range(0, 7));
      Data_In = $urandom;
      e4.Elem_Ready = ($urandom_range(0, 3) != 0);
      cyc("rnd");
    end
    Start = 1'b0;
    e4.Elem_Ready = 1'b1;
    run("drain", 8);

    // 6: two-lane, four-bit instance
    Data2 = {4'hA, 4'h5};
    Count2 = 2'd2;
    Start2 = 1'b1;
    e2.Elem_Ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6 v0", 32'(e2.Elem_Valid), 32'h1);
    chk("t6 d0", 32'(e2.Elem_Data), 32'h5);
    chk("t6 i0", 32'(e2.Elem_Idx), 32'h0);
    chk("t6 l0", 32'(e2.Elem_Last), 32'h0);
    @(negedge CLK);
    Start2 = 1'b0;
    @(posedge CLK);
    #1;
    chk("t6 d1", 32'(e2.Elem_Data), 32'hA);
    chk("t6 i1", 32'(e2.Elem_Idx), 32'h1);
    chk("t6 l1", 32'(e2.Elem_Last), 32'h1);
    @(posedge CLK);
    #1;
    chk("t6 v2", 32'(e2.Elem_Valid), 32'h0);
    chk("t6 done", 32'(Done2), 32'h1);
    @(posedge CLK);
    #1;
    chk("t6 done2", 32'(Done2), 32'h0);
    chk("t6 busy", 32'(Busy2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
